ram_64_8_ctrl: RTL and testbench

Request-side controller for the 64x8 single-port RAM (`ram_64_8`). It accepts read and write requests from a client over a valid/ready handshake and drives the RAM `data`/`addr`/`we` port. It captures `q` and returns read data over a valid/ready response channel. After reset it can optionally clear all 64 locations, so the client always starts from a known memory image.

---
 rtl/ram_64_8_ctrl_if.sv | 22 ++
 rtl/ram_64_8_ctrl.sv | 96 +++++++++
 tb/tb_ram_64_8_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ram_64_8_ctrl_if.sv
// Client-side request/response channel of the 64x8 RAM controller.
// The master issues requests and takes responses; the slave is the controller.
interface ram_64_8_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_64_8_ctrl.sv
// Request-side controller for the 64x8 single-port RAM: optional clear after reset,
// zero-latency writes, and reads returned over a valid/ready response channel.
module ram_64_8_ctrl #(
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] INIT_VALUE     = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_64_8_ctrl_if.slave       bus,
  output logic                 init_done,
  output logic [7:0]           ram_data,
  output logic [5:0]           ram_addr,
  output logic                 ram_we,
  input  logic [7:0]           ram_q
);

  typedef enum logic [1:0] {StInit, StIdle, StRdWait, StResp} state_e;

  state_e     state_q;
  logic [5:0] cnt_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       init_done_q;
  logic       req_fire;
  logic       rsp_fire;

  assign req_fire = rst_n && (state_q == StIdle) && bus.req_valid;
  assign rsp_fire = rsp_valid_q && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= 6'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          // Leave on the edge that writes the last location; the counter never wraps.
          if (!CLEAR_ON_RESET || cnt_q == 6'd63) begin
            state_q     <= StIdle;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 6'd1;
          end
        end
        StIdle: begin
          if (req_fire && !bus.req_we) state_q <= StRdWait;
        end
        StRdWait: begin
          rsp_data_q  <= ram_q;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // In IDLE the RAM port follows the request directly so writes finish on the accept edge.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = 6'd0;
    ram_data = 8'h00;
    if (rst_n) begin
      case (state_q)
        StInit: begin
          if (CLEAR_ON_RESET) begin
            ram_we   = 1'b1;
            ram_addr = cnt_q;
            ram_data = INIT_VALUE;
          end
        end
        StIdle: begin
          ram_we   = bus.req_valid & bus.req_we;
          ram_addr = bus.req_addr;
          ram_data = bus.req_wdata;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = rst_n && (state_q == StIdle);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign init_done     = init_done_q;

endmodule

// File: tb/tb_ram_64_8_ctrl.sv
// Bench for ram_64_8_ctrl: table-driven test-plan vectors, hand-written corner sequences,
// and random traffic checked against an array model of the memory contents.
module tb_ram_64_8_ctrl;

  localparam logic [7:0] InitVal = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_64_8_ctrl_if bus ();

  logic       init_done;
  logic       ram_we;
  logic [7:0] ram_data;
  logic [5:0] ram_addr;
  logic [7:0] ram_q;

  ram_64_8_ctrl #(
    .CLEAR_ON_RESET(1'b1),
    .INIT_VALUE    (InitVal)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .init_done(init_done),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_q    (ram_q)
  );

  // Behavioural ram_64_8: write on we edge, address registered every edge.
  logic [7:0] ram_mem [64];
  logic [5:0] ram_areg = 6'd0;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_areg <= ram_addr;
  end
  assign ram_q = ram_mem[ram_areg];

  logic [7:0] ref_mem [64];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Releases reset and follows the clear walk; expects init_done after exactly 64 edges.
  task automatic release_and_clear();
    int edges;
    edges = 0;
    rst_n = 1'b1;
    #1;
    while (!init_done && edges < 100) begin
      if (edges < 64)
        check("clear_walk", {23'd0, ram_we, ram_addr[5:0], ram_data},
              {23'd0, 1'b1, edges[5:0], InitVal});
      check("init_ready_low", bus.req_ready, 0);
      tick();
      edges++;
    end
    check("init_edges", edges, 64);
    for (int i = 0; i < 64; i++) ref_mem[i] = InitVal;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    check("wr_ready", bus.req_ready, 1);
    check("wr_we", ram_we, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    ref_mem[a] = d;
  endtask

  // Read accepted at edge N: response visible for the edge N+2 handshake.
  task automatic do_read(input logic [5:0] a, input logic [7:0] exp, input int hold);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    bus.req_wdata = 8'h5C;
    #1;
    check("rd_ready", bus.req_ready, 1);
    check("rd_we", ram_we, 0);
    bus.rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rd_wait_valid", bus.rsp_valid, 0);
    check("rd_wait_ready", bus.req_ready, 0);
    tick();
    check("rd_valid", bus.rsp_valid, 1);
    check("rd_data", bus.rsp_data, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_data", bus.rsp_data, exp);
      check("bp_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("rsp_done_valid", bus.rsp_valid, 0);
    check("rsp_done_ready", bus.req_ready, 1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = 6'd0;
    bus.req_wdata = 8'h00;
    bus.rsp_ready = 1'b1;

    vecs.push_back('{0, 6'd0,  8'h00, 8'hA5});
    vecs.push_back('{0, 6'd31, 8'h00, 8'hA5});
    vecs.push_back('{0, 6'd63, 8'h00, 8'hA5});
    vecs.push_back('{1, 6'd0,  8'h01, 8'h00});
    vecs.push_back('{1, 6'd1,  8'h02, 8'h00});
    vecs.push_back('{1, 6'd2,  8'h03, 8'h00});
    vecs.push_back('{0, 6'd0,  8'h00, 8'h01});
    vecs.push_back('{0, 6'd1,  8'h00, 8'h02});
    vecs.push_back('{0, 6'd2,  8'h00, 8'h03});
    vecs.push_back('{1, 6'd1,  8'h04, 8'h00});
    vecs.push_back('{0, 6'd1,  8'h00, 8'h04});
    vecs.push_back('{0, 6'd0,  8'h00, 8'h01});
    vecs.push_back('{1, 6'd63, 8'hFF, 8'h00});
    vecs.push_back('{1, 6'd0,  8'h7E, 8'h00});
    vecs.push_back('{0, 6'd63, 8'h00, 8'hFF});
    vecs.push_back('{0, 6'd0,  8'h00, 8'h7E});

    // Reset values
    tick();
    tick();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_init_done", init_done, 0);
    check("rst_ram_port", {ram_we, ram_addr, ram_data}, 0);

    release_and_clear();

    foreach (vecs[i]) begin
      if (vecs[i].we) do_write(vecs[i].addr, vecs[i].wdata);
      else            do_read(vecs[i].addr, vecs[i].exp, 0);
    end

    // Response backpressure on address 2
    do_read(6'd2, 8'h03, 5);

    // Random traffic against the array model
    for (int n = 0; n < 200; n++) begin
      logic [5:0] a;
      logic [7:0] d;
      a = 6'($urandom_range(0, 63));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, d);
      else do_read(a, ref_mem[a], int'($urandom_range(0, 2)));
    end

    // Reset during RD_WAIT discards the response and re-runs the clear
    do_write(6'd1, 8'h5A);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 6'd1;
    tick();
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstrd_rsp_valid", bus.rsp_valid, 0);
      check("rstrd_init_done", init_done, 0);
      check("rstrd_ram_we", ram_we, 0);
    end
    release_and_clear();
    check("rstrd_init_done_hi", init_done, 1);
    do_read(6'd1, InitVal, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
